// File: rtl/hello_pkg.sv
// Shared definitions for the hello stream arbiter and the hello detector it feeds:
// byte width, one-hot arbiter states and the characters of the target word.
package hello_pkg;

    localparam int BYTE_W    = 8;
    localparam int HELLO_LEN = 5;

    localparam logic [BYTE_W-1:0] CHAR_H = 8'h68;
    localparam logic [BYTE_W-1:0] CHAR_E = 8'h65;
    localparam logic [BYTE_W-1:0] CHAR_L = 8'h6c;
    localparam logic [BYTE_W-1:0] CHAR_O = 8'h6f;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_CLEAR = 3'b010,
        ST_BURST = 3'b100
    } state_e;

    // Expected character at position idx of "hello"; positions past the end map to 'o'.
    function automatic logic [BYTE_W-1:0] hello_char(input int idx);
        logic [BYTE_W-1:0] c;
        case (idx)
            0:       c = CHAR_H;
            1:       c = CHAR_E;
            2, 3:    c = CHAR_L;
            default: c = (idx >= HELLO_LEN - 1) ? CHAR_O : CHAR_H;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant_i, wrapping
// around, reported both as a one-hot vector and as an index.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   last_grant_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic [SRC_W-1:0]   grant_idx_o
);

    logic [SRC_W-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        idx         = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = SRC_W'((int'(last_grant_i) + k) % NUM_SRC);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/hello_stream_arbiter.sv
// Shares one "hello" detector between NUM_SRC byte streams: grants a whole burst at a
// time, clears the detector before each burst and tags every match with its source.
module hello_stream_arbiter
    import hello_pkg::*;
#(
    parameter int  NUM_SRC      = 4,
    parameter int  IDLE_TIMEOUT = 16,
    localparam int SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic [NUM_SRC*BYTE_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_last,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [BYTE_W-1:0]         det_data,
    output logic                      det_valid,
    output logic                      det_clear,
    input  logic                      check_ok,
    output logic                      match_valid,
    output logic [SRC_W-1:0]          match_src,
    output logic [SRC_W-1:0]          grant_id,
    output logic                      busy,
    output logic [7:0]                timeout_cnt
);

    localparam int CNT_W = $clog2(IDLE_TIMEOUT) + 1;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   grant_id_q, grant_id_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]         timeout_cnt_q, timeout_cnt_d;
    logic [BYTE_W-1:0]  det_data_q, det_data_d;
    logic               det_valid_q, det_valid_d;
    logic [SRC_W-1:0]   fwd_src_q;
    logic               check_ok_q;
    logic               match_valid_q;
    logic [SRC_W-1:0]   match_src_q;

    logic [NUM_SRC-1:0] arb_grant;
    logic [SRC_W-1:0]   arb_idx;
    logic               arb_any;
    logic [BYTE_W-1:0]  cur_byte;
    logic               cur_valid;
    logic               cur_last;
    logic               match_rise;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .req_i        (src_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx)
    );

    assign arb_any    = |arb_grant;
    assign cur_valid  = src_valid[grant_id_q];
    assign cur_last   = src_last[grant_id_q];
    assign match_rise = check_ok & ~check_ok_q;

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id_q == SRC_W'(i)) begin
                cur_byte = src_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (state_q == ST_BURST) begin
            src_ready[grant_id_q] = 1'b1;
        end
    end

    // A byte arriving on the last idle cycle is accepted, so it wins over the timeout.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        det_data_d    = det_data_q;
        det_valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_id_d   = arb_idx;
                    last_grant_d = arb_idx;
                    state_d      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                idle_cnt_d = '0;
                state_d    = ST_BURST;
            end
            ST_BURST: begin
                if (cur_valid) begin
                    det_data_d  = cur_byte;
                    det_valid_d = 1'b1;
                    idle_cnt_d  = '0;
                    if (cur_last) begin
                        state_d = ST_IDLE;
                    end
                end else if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= SRC_W'(NUM_SRC - 1);
            idle_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            det_data_q    <= '0;
            det_valid_q   <= 1'b0;
            fwd_src_q     <= '0;
            check_ok_q    <= 1'b0;
            match_valid_q <= 1'b0;
            match_src_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            det_data_q    <= det_data_d;
            det_valid_q   <= det_valid_d;
            check_ok_q    <= check_ok;
            match_valid_q <= match_rise;
            if (det_valid_q) begin
                fwd_src_q <= grant_id_q;
            end
            if (match_rise) begin
                match_src_q <= fwd_src_q;
            end
        end
    end

    assign det_data    = det_data_q;
    assign det_valid   = det_valid_q;
    assign det_clear   = (state_q == ST_CLEAR);
    assign busy        = (state_q == ST_CLEAR) || (state_q == ST_BURST);
    assign match_valid = match_valid_q;
    assign match_src   = match_src_q;
    assign grant_id    = grant_id_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_hello_stream_arbiter.sv
// Directed bench for hello_stream_arbiter; a small behavioural "hello" detector closes
// the loop so match attribution and the per-burst clear can be observed end to end.
module tb_hello_stream_arbiter;
    import hello_pkg::*;

    localparam int NUM_SRC      = 4;
    localparam int IDLE_TIMEOUT = 16;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       last;
    } beat_t;

    logic                 sys_clk;
    logic                 reset;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic [7:0]           det_data;
    logic                 det_valid;
    logic                 det_clear;
    logic                 check_ok;
    logic                 match_valid;
    logic [1:0]           match_src;
    logic [1:0]           grant_id;
    logic                 busy;
    logic [7:0]           timeout_cnt;

    beat_t srcQ[NUM_SRC][$];
    string detLog;
    string grantLog;
    string matchLog;
    int    clearCount;
    int    readyLeak;
    int    passCount;
    int    failCount;
    int    checkCount;

    logic [2:0] detProg;
    logic       detOk;

    hello_stream_arbiter #(
        .NUM_SRC      (NUM_SRC),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .det_data    (det_data),
        .det_valid   (det_valid),
        .det_clear   (det_clear),
        .check_ok    (check_ok),
        .match_valid (match_valid),
        .match_src   (match_src),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Detector model: holds check_ok high after a completed "hello" until the next byte or clear.
    always @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            detProg <= 3'd0;
            detOk   <= 1'b0;
        end else if (det_clear) begin
            detProg <= 3'd0;
            detOk   <= 1'b0;
        end else if (det_valid) begin
            if (det_data == hello_char(int'(detProg))) begin
                if (int'(detProg) == HELLO_LEN - 1) begin
                    detProg <= 3'd0;
                    detOk   <= 1'b1;
                end else begin
                    detProg <= detProg + 3'd1;
                    detOk   <= 1'b0;
                end
            end else begin
                detProg <= (det_data == CHAR_H) ? 3'd1 : 3'd0;
                detOk   <= 1'b0;
            end
        end
    end

    assign check_ok = detOk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkText(input string tag, input string observed, input string expected);
        checkCount++;
        assert (observed == expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed \"%s\", expected \"%s\"", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [7:0] data, input logic last);
        beat_t b;
        b.v    = 1'b1;
        b.d    = data;
        b.last = last;
        srcQ[src].push_back(b);
    endtask

    task automatic applyGap(input int src, input int n);
        beat_t b;
        b.v    = 1'b0;
        b.d    = 8'h00;
        b.last = 1'b0;
        for (int i = 0; i < n; i++) srcQ[src].push_back(b);
    endtask

    task automatic sendString(input int src, input string s, input logic lastOnEnd);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(src, s[i], lastOnEnd && (i == s.len() - 1));
        end
    endtask

    task automatic present();
        for (int s = 0; s < NUM_SRC; s++) begin
            if (srcQ[s].size() > 0) begin
                src_valid[s]         = srcQ[s][0].v;
                src_data[s*8 +: 8]   = srcQ[s][0].d;
                src_last[s]          = srcQ[s][0].last;
            end else begin
                src_valid[s]         = 1'b0;
                src_data[s*8 +: 8]   = 8'h00;
                src_last[s]          = 1'b0;
            end
        end
    endtask

    task automatic clearLogs();
        detLog     = "";
        grantLog   = "";
        matchLog   = "";
        clearCount = 0;
        readyLeak  = 0;
    endtask

    function automatic bit queuesEmpty();
        bit e;
        e = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) if (srcQ[s].size() > 0) e = 1'b0;
        return e;
    endfunction

    // One clock: retire accepted or gap beats, drive the next ones, log what the DUT did.
    task automatic stepCycle();
        logic [NUM_SRC-1:0] acc;
        acc = src_valid & src_ready;
        @(posedge sys_clk);
        #1;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (srcQ[s].size() > 0) begin
                if (!srcQ[s][0].v || acc[s]) void'(srcQ[s].pop_front());
            end
        end
        present();
        if (det_valid) detLog = $sformatf("%s%c", detLog, det_data);
        if (det_clear) begin
            clearCount++;
            grantLog = $sformatf("%s%0d", grantLog, grant_id);
        end
        if (match_valid) matchLog = $sformatf("%s%0d", matchLog, match_src);
        if ($countones(src_ready) > 1) readyLeak++;
        if (busy && grant_id == 2'd1 && src_ready[3]) readyLeak++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic runUntilIdle(input string tag, input int limit);
        int n;
        n = 0;
        while (!(queuesEmpty() && !busy) && n < limit) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_done"}, 32'(n < limit), 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) srcQ[s].delete();
        present();
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        clearLogs();
    endtask

    initial begin
        string upper;
        string lower;
        passCount  = 0;
        failCount  = 0;
        checkCount = 0;
        clearLogs();
        reset     = 1'b1;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        repeat (2) @(posedge sys_clk);
        #1;

        $display("[TB] reset values");
        checkOutput("rst_src_ready",   32'(src_ready),   32'd0);
        checkOutput("rst_det_data",    32'(det_data),    32'd0);
        checkOutput("rst_det_valid",   32'(det_valid),   32'd0);
        checkOutput("rst_det_clear",   32'(det_clear),   32'd0);
        checkOutput("rst_match_valid", 32'(match_valid), 32'd0);
        checkOutput("rst_match_src",   32'(match_src),   32'd0);
        checkOutput("rst_grant_id",    32'(grant_id),    32'd0);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        checkOutput("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        reset = 1'b0;

        $display("[TB] source 0 sends hello");
        clearLogs();
        sendString(0, "hello", 1'b1);
        present();
        stepCycle();
        checkOutput("t1_clear_pulse",   32'(det_clear), 32'd1);
        checkOutput("t1_clear_busy",    32'(busy),      32'd1);
        checkOutput("t1_clear_noready", 32'(src_ready), 32'd0);
        checkOutput("t1_clear_grant",   32'(grant_id),  32'd0);
        stepCycle();
        checkOutput("t1_burst_noclear", 32'(det_clear), 32'd0);
        checkOutput("t1_burst_ready",   32'(src_ready), 32'b0001);
        runUntilIdle("t1", 100);
        runCycles(6);
        checkText("t1_det_bytes", detLog, "hello");
        checkText("t1_match_src", matchLog, "0");
        checkText("t1_grants", grantLog, "0");
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);

        $display("[TB] sources 1 and 3 request together");
        doReset();
        sendString(1, "abc", 1'b1);
        sendString(3, "xyz", 1'b1);
        present();
        stepCycle();
        checkOutput("t2_first_clear", 32'(det_clear), 32'd1);
        checkOutput("t2_first_grant", 32'(grant_id),  32'd1);
        runUntilIdle("t2", 100);
        runCycles(4);
        checkText("t2_grants", grantLog, "13");
        checkText("t2_det_bytes", detLog, "abcxyz");
        checkOutput("t2_clear_count", 32'(clearCount), 32'd2);
        checkOutput("t2_ready_leak",  32'(readyLeak),  32'd0);
        checkText("t2_no_match", matchLog, "");

        $display("[TB] source 2 idles into a timeout, source 0 finishes the word");
        clearLogs();
        sendString(2, "hel", 1'b0);
        present();
        runCycles(20);
        checkOutput("t3_still_busy",    32'(busy),        32'd1);
        checkOutput("t3_no_timeout_yet", 32'(timeout_cnt), 32'd0);
        checkOutput("t3_grant_2",       32'(grant_id),    32'd2);
        stepCycle();
        checkOutput("t3_revoked",       32'(busy),        32'd0);
        checkOutput("t3_timeout_cnt",   32'(timeout_cnt), 32'd1);
        sendString(0, "lo", 1'b1);
        present();
        runUntilIdle("t3", 100);
        runCycles(6);
        checkText("t3_det_bytes", detLog, "hello");
        checkText("t3_grants", grantLog, "20");
        checkText("t3_no_cross_match", matchLog, "");

        $display("[TB] all sources request continuously");
        doReset();
        upper = "ABCD";
        lower = "abcd";
        for (int s = 0; s < NUM_SRC; s++) applyStimulus(s, upper[s], 1'b1);
        for (int s = 0; s < NUM_SRC; s++) applyStimulus(s, lower[s], 1'b1);
        present();
        runUntilIdle("t4", 200);
        runCycles(4);
        checkText("t4_grants", grantLog, "01230123");
        checkText("t4_det_bytes", detLog, "ABCDabcd");
        checkOutput("t4_clear_count", 32'(clearCount), 32'd8);
        checkOutput("t4_ready_leak",  32'(readyLeak),  32'd0);

        $display("[TB] reset in the middle of a burst");
        clearLogs();
        sendString(1, "pq", 1'b1);
        present();
        runCycles(3);
        checkOutput("t5_pre_grant", 32'(grant_id),  32'd1);
        checkOutput("t5_pre_valid", 32'(det_valid), 32'd1);
        reset = 1'b1;
        #2;
        checkOutput("t5_async_src_ready", 32'(src_ready), 32'd0);
        checkOutput("t5_async_det_valid", 32'(det_valid), 32'd0);
        checkOutput("t5_async_det_data",  32'(det_data),  32'd0);
        checkOutput("t5_async_det_clear", 32'(det_clear), 32'd0);
        checkOutput("t5_async_grant_id",  32'(grant_id),  32'd0);
        checkOutput("t5_async_busy",      32'(busy),      32'd0);
        for (int s = 0; s < NUM_SRC; s++) srcQ[s].delete();
        present();
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        clearLogs();
        applyStimulus(0, "u", 1'b1);
        applyStimulus(2, "v", 1'b1);
        present();
        runUntilIdle("t5", 100);
        runCycles(4);
        checkText("t5_restart_grants", grantLog, "02");
        checkText("t5_det_bytes", detLog, "uv");

        $display("[TB] source 1 sends hhello with a 15-cycle stall");
        clearLogs();
        sendString(1, "hhel", 1'b0);
        applyGap(1, IDLE_TIMEOUT - 1);
        sendString(1, "lo", 1'b1);
        present();
        runUntilIdle("t6", 200);
        runCycles(6);
        checkText("t6_det_bytes", detLog, "hhello");
        checkText("t6_match_src", matchLog, "1");
        checkText("t6_grants", grantLog, "1");
        checkOutput("t6_no_timeout", 32'(timeout_cnt), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
